// File: rtl/bcd_ctrl_pkg.sv
// Shared types for the BCD down-counter: digit type, BCD limit and FSM state encoding.
package bcd_ctrl_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/bcd_digit_down.sv
// One BCD digit of the down-count chain; borrows into the next digit when it wraps 0 -> 9.
module bcd_digit_down
    import bcd_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  bcd_t preset,
    input  logic dec_in,
    output bcd_t Q,
    output logic borrow_out
);

    always_ff @(posedge clk) begin
        if (rst || load) begin
            Q <= preset;
        end else if (dec_in) begin
            Q <= (Q == '0) ? BCD_MAX : Q - 4'd1;
        end
    end

    assign borrow_out = dec_in && (Q == '0);

    // Presets above 9 would leave the digit outside BCD range.
    always_ff @(posedge clk) begin
        assert (preset <= BCD_MAX)
            else $error("bcd_digit_down: preset %0d is not a BCD digit", preset);
    end

endmodule

// File: rtl/bcd_down_counter_ctrl.sv
// 4-digit BCD down-counter with prescaler and IDLE/RUN/PAUSE/DONE control.
// Optional AUTORELOAD_EN: terminal tick reloads the preset and pulses done_o instead of stopping.
module bcd_down_counter_ctrl
    import bcd_ctrl_pkg::*;
#(
    parameter logic [3:0]  PRESET3  = 4'd9,
    parameter logic [3:0]  PRESET2  = 4'd6,
    parameter logic [3:0]  PRESET1  = 4'd7,
    parameter logic [3:0]  PRESET0  = 4'd5,
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic       pause_i,
    input  logic       load_i,
    output logic [3:0] Qdata3,
    output logic [3:0] Qdata2,
    output logic [3:0] Qdata1,
    output logic [3:0] Qdata0,
    output logic       tick_o,
    output logic       done_o,
    output logic [1:0] state_o
);

`ifdef AUTORELOAD_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    localparam int unsigned DW          = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST  = DW'(TICK_DIV - 1);
    localparam bit          PRESET_ZERO = ({PRESET3, PRESET2, PRESET1, PRESET0} == 16'h0000);
    localparam bcd_t        PRESETS [4] = '{PRESET0, PRESET1, PRESET2, PRESET3};

    state_t        state;
    logic [DW-1:0] div;
    bcd_t          q [4];
    logic [3:0]    dec;
    logic [3:0]    brw;
    logic          tick_now;
    logic          term;
    logic          reload_now;
    logic          digit_load;

    assign tick_now = (state == RUN) && (div == DIV_LAST);
    // Next decrement lands on 0000 (or, with autoreload and a 0000 preset, would underflow).
    assign term     = ({q[3], q[2], q[1]} == 12'h000) && (q[0] <= 4'd1);

    assign reload_now = AUTO && tick_now && term && !load_i;
    assign digit_load = load_i || reload_now;
    assign dec[0]     = tick_now && !digit_load;
    assign dec[3:1]   = brw[2:0];

    for (genvar i = 0; i < 4; i++) begin : g_digit
        bcd_digit_down u_digit (
            .clk        (clk),
            .rst        (rst),
            .load       (digit_load),
            .preset     (PRESETS[i]),
            .dec_in     (dec[i]),
            .Q          (q[i]),
            .borrow_out (brw[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            div    <= '0;
            tick_o <= 1'b0;
            done_o <= 1'b0;
        end else if (load_i) begin
            state  <= IDLE;
            div    <= '0;
            tick_o <= 1'b0;
            done_o <= 1'b0;
        end else begin
            tick_o <= tick_now;
            done_o <= AUTO && tick_now && term;
            case (state)
                IDLE: begin
                    if (!pause_i && start_i) begin
                        div <= '0;
                        if (!AUTO && PRESET_ZERO) begin
                            state  <= DONE;
                            done_o <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    div <= tick_now ? '0 : div + 1'b1;
                    // Terminal count outranks a coincident pause.
                    if (!AUTO && tick_now && term) begin
                        state  <= DONE;
                        done_o <= 1'b1;
                    end else if (pause_i) begin
                        state <= PAUSE;
                    end
                end
                PAUSE: begin
                    if (!pause_i && start_i) state <= RUN;
                end
                DONE: begin
                    done_o <= 1'b1;
                end
            endcase
        end
    end

    // A borrow out of the thousands digit would mean the chain underflowed past 0000.
    always_ff @(posedge clk) begin
        if (!rst) assert (!brw[3]) else $error("bcd_down_counter_ctrl: borrow chain underflow");
    end

    assign Qdata3  = q[3];
    assign Qdata2  = q[2];
    assign Qdata1  = q[1];
    assign Qdata0  = q[0];
    assign state_o = state;

endmodule

// File: tb/tb_bcd_down_counter_ctrl.sv
// Self-checking bench: four counters with different presets share random stimulus
// and are compared each cycle against an integer-valued reference model.
module tb_bcd_down_counter_ctrl;

    localparam int TD = 4;
    localparam logic [15:0] PR [4] = '{16'h9675, 16'h1000, 16'h0002, 16'h0000};

`ifdef AUTORELOAD_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1, start = 1'b0, pause = 1'b0, load = 1'b0;
    logic [3:0] q3 [4], q2 [4], q1 [4], q0 [4];
    logic       tick [4], done [4];
    logic [1:0] st [4];

    int n_pass = 0, n_total = 0;
    int pv [4], m_val [4], m_st [4], m_div [4];
    bit m_tick [4], m_done [4];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        bcd_down_counter_ctrl #(
            .PRESET3  (PR[g][15:12]),
            .PRESET2  (PR[g][11:8]),
            .PRESET1  (PR[g][7:4]),
            .PRESET0  (PR[g][3:0]),
            .TICK_DIV (TD)
        ) u_dut (
            .clk     (clk),
            .rst     (rst),
            .start_i (start),
            .pause_i (pause),
            .load_i  (load),
            .Qdata3  (q3[g]),
            .Qdata2  (q2[g]),
            .Qdata1  (q1[g]),
            .Qdata0  (q0[g]),
            .tick_o  (tick[g]),
            .done_o  (done[g]),
            .state_o (st[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    function automatic int bcd2int(input logic [15:0] b);
        return int'(b[15:12]) * 1000 + int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [15:0] int2bcd(input int v);
        logic [15:0] r;
        r[15:12] = 4'(v / 1000);
        r[11:8]  = 4'((v / 100) % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[3:0]   = 4'(v % 10);
        return r;
    endfunction

    // States as integers: 0 idle, 1 run, 2 pause, 3 done.
    task automatic model_step(input bit r, input bit s, input bit p, input bit l);
        for (int i = 0; i < 4; i++) begin
            m_tick[i] = 1'b0;
            m_done[i] = 1'b0;
            if (r || l) begin
                m_val[i] = pv[i];
                m_div[i] = 0;
                m_st[i]  = 0;
            end else begin
                case (m_st[i])
                    0: if (!p && s) begin
                        m_div[i] = 0;
                        m_st[i]  = (!AUTO && pv[i] == 0) ? 3 : 1;
                    end
                    1: begin
                        if (m_div[i] == TD - 1) begin
                            m_div[i]  = 0;
                            m_tick[i] = 1'b1;
                            if (m_val[i] <= 1) begin
                                if (AUTO) begin
                                    m_val[i]  = pv[i];
                                    m_done[i] = 1'b1;
                                end else begin
                                    m_val[i] = 0;
                                    m_st[i]  = 3;
                                end
                            end else begin
                                m_val[i] = m_val[i] - 1;
                            end
                        end else begin
                            m_div[i] = m_div[i] + 1;
                        end
                        if (m_st[i] == 1 && p) m_st[i] = 2;
                    end
                    2: if (!p && s) m_st[i] = 1;
                    default: ;
                endcase
                if (!AUTO && m_st[i] == 3) m_done[i] = 1'b1;
            end
        end
    endtask

    task automatic step(input bit r, input bit s, input bit p, input bit l);
        rst = r; start = s; pause = p; load = l;
        @(posedge clk);
        model_step(r, s, p, l);
        #1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("digits%0d", i), {q3[i], q2[i], q1[i], q0[i]}, int2bcd(m_val[i]));
            check($sformatf("tick%0d", i), tick[i], m_tick[i]);
            check($sformatf("done%0d", i), done[i], m_done[i]);
            check($sformatf("state%0d", i), st[i], m_st[i]);
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) pv[i] = bcd2int(PR[i]);

        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        check("rst_digits", {q3[0], q2[0], q1[0], q0[0]}, 16'h9675);
        check("rst_state", st[0], 2'd0);
        check("rst_done", done[0], 1'b0);
        check("rst_tick", tick[0], 1'b0);

        step(0, 1, 0, 0);
        repeat (3) step(0, 0, 0, 0);
        check("tick_early", tick[0], 1'b0);
        step(0, 0, 0, 0);
        check("first_tick", tick[0], 1'b1);
        check("dec_9674", {q3[0], q2[0], q1[0], q0[0]}, 16'h9674);
        check("borrow_0999", {q3[1], q2[1], q1[1], q0[1]}, 16'h0999);
        check("dec_0001", {q3[2], q2[2], q1[2], q0[2]}, 16'h0001);
        repeat (4) step(0, 0, 0, 0);
        check("borrow_0998", {q3[1], q2[1], q1[1], q0[1]}, 16'h0998);
`ifndef AUTORELOAD_EN
        check("zero_preset_done", st[3], 2'd3);
        check("term_state", st[2], 2'd3);
        check("term_done", done[2], 1'b1);
        check("term_digits", {q3[2], q2[2], q1[2], q0[2]}, 16'h0000);
        step(0, 1, 0, 0);
        repeat (4) step(0, 0, 0, 0);
        check("done_ignores_start", st[2], 2'd3);
`else
        check("reload_state", st[2], 2'd1);
        check("reload_done", done[2], 1'b1);
        check("reload_digits", {q3[2], q2[2], q1[2], q0[2]}, 16'h0002);
        step(0, 0, 0, 0);
        check("reload_done_pulse", done[2], 1'b0);
`endif
        step(0, 0, 0, 1);
        check("load_digits", {q3[2], q2[2], q1[2], q0[2]}, 16'h0002);
        check("load_state", st[2], 2'd0);

        // Pause two cycles into a period, then resume the partial period.
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        repeat (10) begin
            step(0, 0, 0, 0);
            check("pause_no_tick", tick[0], 1'b0);
        end
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        check("resume_early", tick[0], 1'b0);
        step(0, 0, 0, 0);
        check("resume_tick", tick[0], 1'b1);

        // Load on the edge where a tick would land.
        step(0, 0, 0, 1);
        step(0, 1, 0, 0);
        repeat (3) step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        check("load_on_tick_digits", {q3[0], q2[0], q1[0], q0[0]}, 16'h9675);
        check("load_on_tick_state", st[0], 2'd0);
        check("load_on_tick_tick", tick[0], 1'b0);

        step(0, 1, 0, 0);
        step(1, 1, 0, 1);
        check("rst_prio_digits", {q3[0], q2[0], q1[0], q0[0]}, 16'h9675);
        check("rst_prio_state", st[0], 2'd0);

        repeat (3000) begin
            step($urandom_range(0, 199) == 0, ($urandom % 5) == 0,
                 ($urandom % 10) == 0, ($urandom % 60) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
